copper_exec: RTL and testbench
==============================

Name: copper_exec

Overview:
- Copper instruction engine.
- Fetches 2-word instructions from the 2048x16 copper program BRAM; 1-cycle registered read latency, read port gated by rd_en.
- Compares them against video beam position and issues colour-palette writes mid-frame.
- Sits between the copper BRAM read port and the palette write port, clocked in the pixel clock domain.

Parameters:
- PC_W, 11, copper program word-address width (2048 words).
- POS_W, 11, beam h/v counter width.
- PAL_W, 8, palette index width.

Ports:
- clk  in  1  pixel clock
- reset_i  in  1  synchronous active-high reset
- cop_en_i  in  1  copper enable; low = idle, PC held at 0
- h_count_i  in  POS_W  current beam X
- v_count_i  in  POS_W  current beam Y
- end_of_frame_i  in  1  one-cycle pulse at last pixel of frame
- cop_rd_en_o  out  1  program BRAM read enable
- cop_rd_addr_o  out  PC_W  program BRAM word address
- cop_rd_data_i  in  16  program word, valid the cycle after cop_rd_en_o
- pal_wr_en_o  out  1  palette write strobe (one cycle)
- pal_wr_addr_o  out  PAL_W  palette index
- pal_wr_data_o  out  16  palette data (0RGB 4:4:4:4)

Behaviour:
- Reset: every output 0; state IDLE; PC=0; latched w0/w1=0.
- Instruction = w0 at PC, w1 at PC+1. Opcode = w0[15:12]:
  - 0x0 WAIT: Y=w0[10:0], X=w1[14:4], flags=w1[3:0]. flag0=ignore Y, flag1=ignore X.
  - 0x2 SKIP: same fields as WAIT.
  - 0x4 JMP: target = w0[10:0].
  - 0xB MOVEP: index = w0[7:0], data = w1.
  - Any other opcode: NOP, PC+=2.
- Condition met = (flag0 | v_count_i>=Y) & (flag1 | h_count_i>=X). Compare is unsigned.
- States:
  - IDLE: go to FETCH0 on cop_en_i & end_of_frame_i.
  - FETCH0: rd_en=1, addr=PC.
  - FETCH1: latch w0 from cop_rd_data_i; rd_en=1, addr=PC+1.
  - EXEC: w1 = cop_rd_data_i.
    - MOVEP: registered palette write, visible next cycle; PC+=2; go to FETCH0.
    - JMP: PC=target; go to FETCH0.
    - SKIP: condition met → PC+=4, else PC+=2; go to FETCH0.
    - WAIT with flags[1:0]=11 (NEXTF): go to FRAME.
    - WAIT, condition met: PC+=2; go to FETCH0.
    - WAIT, condition not met: go to WAIT.
  - WAIT: re-evaluate the condition each cycle with latched w0/w1. When met: PC+=2, go to FETCH0.
  - FRAME: hold; no fetches.
- Throughput: 3 cycles per executed instruction.
- Latency: end_of_frame_i at cycle t → FETCH0 at t+1 → MOVEP at addr 0 gives pal_wr_en_o high at t+4 for exactly one cycle.
- end_of_frame_i has top priority in every state except IDLE with cop_en_i low:
  - next state = FETCH0, PC=0.
  - Any in-flight instruction is abandoned; no palette write is issued for it.
- cop_en_i low (any state): next cycle IDLE, PC=0, rd_en=0. pal_wr_en_o is forced 0 from the next cycle.
- PC arithmetic is modulo 2^PC_W. PC=2047 fetches w1 from address 0; PC+2/PC+4 wrap.
- cop_rd_en_o is 0 outside FETCH0/FETCH1, so the BRAM output is held.
- reset_i mid-instruction: returns to IDLE next cycle, no pending palette write, all outputs 0.

Decomposition:
- Add to the shared xosera_pkg:
  - opcode constants: OP_WAIT=4'h0, OP_SKIP=4'h2, OP_JMP=4'h4, OP_MOVEP=4'hB;
  - flag bit indices: FLAG_IGN_Y=0, FLAG_IGN_X=1;
  - copper state enum typedef.
- No sub-module; the condition comparator stays inline as combinational logic shared by EXEC and WAIT.

Test Plan:
- Program [0]=B000/0F00, [2]=0000/0003; pulse eof → pal_wr_en_o=1 at t+4 with addr 0x00, data 0x0F00; afterwards no further reads until the next eof.
- Program [0]=00A0/0002, [2]=B005/00F0; sweep v_count 0..200 → no palette write before v=160; one write (idx 5, 0x00F0) 4 cycles after v_count reaches 160, independent of h_count.
- SKIP: [0]=20A0/0002, [2]=4010/0000, [4]=B001/000F, [16]=B002/0F00, then nextf at 6 and 18 → at v=100 write idx 2 data 0x0F00; at v=200 write idx 1 data 0x000F.
- Wrap: JMP to 2046, [2046]=B003/1234 (w1 at 2047), [0]=nextf → write idx 3 data 0x1234; next fetch address 0.
- eof pulse while in WAIT for Y=400 at v=300 → PC restarts at 0 within 1 cycle; no write from the abandoned instruction.
- Deassert cop_en_i during FETCH1 of a MOVEP → no palette write, cop_rd_en_o=0 next cycle; reset_i during EXEC → all outputs 0 next cycle.

Source files
------------

// File: rtl/xosera_pkg.sv
// Shared definitions for the copper engine: opcodes, WAIT/SKIP flag bits and FSM states.
package xosera_pkg;

    localparam logic [3:0] OP_WAIT  = 4'h0;
    localparam logic [3:0] OP_SKIP  = 4'h2;
    localparam logic [3:0] OP_JMP   = 4'h4;
    localparam logic [3:0] OP_MOVEP = 4'hB;

    localparam int unsigned FLAG_IGN_Y = 0;
    localparam int unsigned FLAG_IGN_X = 1;

    typedef enum logic [2:0] {
        CopIdle,
        CopFetch0,
        CopFetch1,
        CopExec,
        CopWait,
        CopFrame
    } cop_state_t;

endpackage

// File: rtl/copper_exec.sv
// Copper instruction engine: fetches 2-word instructions from program BRAM, waits on the
// beam position and issues palette writes mid-frame.
module copper_exec
    import xosera_pkg::*;
#(
    parameter int unsigned PC_W  = 11,
    parameter int unsigned POS_W = 11,
    parameter int unsigned PAL_W = 8
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             cop_en_i,
    input  logic [POS_W-1:0] h_count_i,
    input  logic [POS_W-1:0] v_count_i,
    input  logic             end_of_frame_i,
    output logic             cop_rd_en_o,
    output logic [PC_W-1:0]  cop_rd_addr_o,
    input  logic [15:0]      cop_rd_data_i,
    output logic             pal_wr_en_o,
    output logic [PAL_W-1:0] pal_wr_addr_o,
    output logic [15:0]      pal_wr_data_o
);

    cop_state_t       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    // Only the instruction fields that are actually consumed are latched.
    logic [3:0]       op_q, op_d;
    logic [10:0]      arg_q, arg_d;
    logic [10:0]      wx_q, wx_d;
    logic [1:0]       flags_q, flags_d;
    logic             pal_wr_en_q, pal_wr_en_d;
    logic [PAL_W-1:0] pal_wr_addr_q, pal_wr_addr_d;
    logic [15:0]      pal_wr_data_q, pal_wr_data_d;

    logic [10:0]      cur_x;
    logic [1:0]       cur_flags;
    logic             cond_met;

    // In EXEC w1 is still on the BRAM bus; in WAIT it comes from the latch.
    always_comb begin
        cur_x     = (state_q == CopExec) ? cop_rd_data_i[14:4] : wx_q;
        cur_flags = (state_q == CopExec) ? cop_rd_data_i[1:0] : flags_q;
        cond_met  = (cur_flags[FLAG_IGN_Y] | (v_count_i >= POS_W'(arg_q))) &
                    (cur_flags[FLAG_IGN_X] | (h_count_i >= POS_W'(cur_x)));
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        op_d          = op_q;
        arg_d         = arg_q;
        wx_d          = wx_q;
        flags_d       = flags_q;
        pal_wr_en_d   = 1'b0;
        pal_wr_addr_d = pal_wr_addr_q;
        pal_wr_data_d = pal_wr_data_q;
        if (!cop_en_i) begin
            state_d = CopIdle;
            pc_d    = '0;
        end else if (end_of_frame_i) begin
            state_d = CopFetch0;
            pc_d    = '0;
        end else begin
            unique case (state_q)
                CopIdle:   ;
                CopFetch0: state_d = CopFetch1;
                CopFetch1: begin
                    op_d    = cop_rd_data_i[15:12];
                    arg_d   = cop_rd_data_i[10:0];
                    state_d = CopExec;
                end
                CopExec: begin
                    wx_d    = cop_rd_data_i[14:4];
                    flags_d = cop_rd_data_i[1:0];
                    state_d = CopFetch0;
                    pc_d    = pc_q + PC_W'(2);
                    case (op_q)
                        OP_MOVEP: begin
                            pal_wr_en_d   = 1'b1;
                            pal_wr_addr_d = PAL_W'(arg_q[7:0]);
                            pal_wr_data_d = cop_rd_data_i;
                        end
                        OP_JMP:  pc_d = PC_W'(arg_q);
                        OP_SKIP: if (cond_met) pc_d = pc_q + PC_W'(4);
                        OP_WAIT: begin
                            if (&cur_flags) begin
                                state_d = CopFrame;
                                pc_d    = pc_q;
                            end else if (!cond_met) begin
                                state_d = CopWait;
                                pc_d    = pc_q;
                            end
                        end
                        default: ;
                    endcase
                end
                CopWait: begin
                    if (cond_met) begin
                        state_d = CopFetch0;
                        pc_d    = pc_q + PC_W'(2);
                    end
                end
                CopFrame: ;
                default:  state_d = CopIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q       <= CopIdle;
            pc_q          <= '0;
            op_q          <= '0;
            arg_q         <= '0;
            wx_q          <= '0;
            flags_q       <= '0;
            pal_wr_en_q   <= 1'b0;
            pal_wr_addr_q <= '0;
            pal_wr_data_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            op_q          <= op_d;
            arg_q         <= arg_d;
            wx_q          <= wx_d;
            flags_q       <= flags_d;
            pal_wr_en_q   <= pal_wr_en_d;
            pal_wr_addr_q <= pal_wr_addr_d;
            pal_wr_data_q <= pal_wr_data_d;
        end
    end

    always_comb begin
        cop_rd_en_o   = (state_q == CopFetch0) || (state_q == CopFetch1);
        cop_rd_addr_o = (state_q == CopFetch1) ? pc_q + PC_W'(1) : pc_q;
        pal_wr_en_o   = pal_wr_en_q;
        pal_wr_addr_o = pal_wr_addr_q;
        pal_wr_data_o = pal_wr_data_q;
    end

endmodule

// File: tb/tb_copper_exec.sv
// Directed bench for copper_exec: instruction-level program model plus literal checks.
module tb_copper_exec;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        cop_en_i = 1'b0;
    logic        end_of_frame_i = 1'b0;
    logic [10:0] h_count_i = '0;
    logic [10:0] v_count_i = '0;
    logic        cop_rd_en_o;
    logic [10:0] cop_rd_addr_o;
    logic [15:0] cop_rd_data_i = '0;
    logic        pal_wr_en_o;
    logic [7:0]  pal_wr_addr_o;
    logic [15:0] pal_wr_data_o;

    copper_exec #(
        .PC_W (11),
        .POS_W(11),
        .PAL_W(8)
    ) dut (
        .clk           (clk),
        .reset_i       (reset_i),
        .cop_en_i      (cop_en_i),
        .h_count_i     (h_count_i),
        .v_count_i     (v_count_i),
        .end_of_frame_i(end_of_frame_i),
        .cop_rd_en_o   (cop_rd_en_o),
        .cop_rd_addr_o (cop_rd_addr_o),
        .cop_rd_data_i (cop_rd_data_i),
        .pal_wr_en_o   (pal_wr_en_o),
        .pal_wr_addr_o (pal_wr_addr_o),
        .pal_wr_data_o (pal_wr_data_o)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:2047];
    always @(posedge clk) if (cop_rd_en_o) cop_rd_data_i <= mem[cop_rd_addr_o];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Program model: walks the instruction list directly, 3 cycles per instruction.
    int   m_mode = 0;  // 0 idle, 1 running, 2 waiting on beam, 3 done for frame
    int   m_step = 0;
    int   m_pc = 0;
    logic e_pal_en = 1'b0;
    int   e_pal_addr = 0;
    int   e_pal_data = 0;
    logic e_rd_en = 1'b0;
    int   e_rd_addr = 0;

    function automatic bit cond_ok(input int w0, input int w1);
        return ((w1 & 1) != 0 || int'(v_count_i) >= (w0 & 'h7FF)) &&
               ((w1 & 2) != 0 || int'(h_count_i) >= ((w1 >> 4) & 'h7FF));
    endfunction

    always @(posedge clk) begin : model
        int w0, w1;
        e_pal_en = 1'b0;
        w0 = int'(mem[m_pc]);
        w1 = int'(mem[(m_pc + 1) % 2048]);
        if (reset_i) begin
            m_mode = 0; m_pc = 0; m_step = 0; e_pal_addr = 0; e_pal_data = 0;
        end else if (!cop_en_i) begin
            m_mode = 0; m_pc = 0;
        end else if (end_of_frame_i) begin
            m_mode = 1; m_step = 0; m_pc = 0;
        end else if (m_mode == 1) begin
            if (m_step < 2) m_step++;
            else begin
                m_step = 0;
                case (w0 >> 12)
                    'hB: begin
                        e_pal_en = 1'b1; e_pal_addr = w0 & 'hFF; e_pal_data = w1; m_pc += 2;
                    end
                    4: m_pc = w0 & 'h7FF;
                    2: m_pc += cond_ok(w0, w1) ? 4 : 2;
                    0: begin
                        if ((w1 & 3) == 3) m_mode = 3;
                        else if (cond_ok(w0, w1)) m_pc += 2;
                        else m_mode = 2;
                    end
                    default: m_pc += 2;
                endcase
                m_pc %= 2048;
            end
        end else if (m_mode == 2) begin
            if (cond_ok(w0, w1)) begin
                m_pc = (m_pc + 2) % 2048; m_mode = 1; m_step = 0;
            end
        end
        e_rd_en   = (m_mode == 1 && m_step < 2);
        e_rd_addr = (m_pc + m_step) % 2048;
    end

    typedef struct {int c; int addr; int data;} wr_t;
    wr_t wlog[$];
    bit  rd_en_at [0:8191];
    int  rd_addr_at [0:8191];

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("pal_wr_en", int'(pal_wr_en_o), int'(e_pal_en));
            if (e_pal_en) begin
                check("pal_wr_addr", int'(pal_wr_addr_o), e_pal_addr);
                check("pal_wr_data", int'(pal_wr_data_o), e_pal_data);
            end
            check("rd_en", int'(cop_rd_en_o), int'(e_rd_en));
            if (e_rd_en) check("rd_addr", int'(cop_rd_addr_o), e_rd_addr);
            if (pal_wr_en_o) wlog.push_back('{cyc, int'(pal_wr_addr_o), int'(pal_wr_data_o)});
            if (cyc < 8192) begin
                rd_en_at[cyc]   = cop_rd_en_o;
                rd_addr_at[cyc] = int'(cop_rd_addr_o);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_eof(output int c);
        end_of_frame_i = 1'b1;
        c = cyc;
        tick(1);
        end_of_frame_i = 1'b0;
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 2048; i++) mem[i] = 16'hF000;
    endtask

    task automatic check_write(input string name, input int idx, input int c,
                               input int addr, input int data);
        check({name, "_count"}, (wlog.size() > idx) ? 1 : 0, 1);
        if (wlog.size() > idx) begin
            check({name, "_cycle"}, wlog[idx].c, c);
            check({name, "_idx"}, wlog[idx].addr, addr);
            check({name, "_data"}, wlog[idx].data, data);
        end
    endtask

    initial begin
        int t, t2, c160, nrd;
        fill_nop();
        tick(3);
        check("rst_pal_en", int'(pal_wr_en_o), 0);
        check("rst_pal_addr", int'(pal_wr_addr_o), 0);
        check("rst_pal_data", int'(pal_wr_data_o), 0);
        check("rst_rd_en", int'(cop_rd_en_o), 0);
        check("rst_rd_addr", int'(cop_rd_addr_o), 0);
        reset_i = 1'b0;
        cop_en_i = 1'b1;
        tick(3);
        check("idle_no_eof_rd_en", int'(cop_rd_en_o), 0);

        // MOVEP then NEXTF
        mem[0] = 16'hB000; mem[1] = 16'h0F00; mem[2] = 16'h0000; mem[3] = 16'h0003;
        wlog.delete();
        pulse_eof(t);
        tick(30);
        check("t1_writes", wlog.size(), 1);
        check_write("t1", 0, t + 4, 0, 'h0F00);
        nrd = 0;
        for (int i = t + 1; i < t + 30; i++) nrd += int'(rd_en_at[i]);
        check("t1_reads", nrd, 4);

        // WAIT for v >= 160 ignoring X, then MOVEP
        fill_nop();
        mem[0] = 16'h00A0; mem[1] = 16'h0002; mem[2] = 16'hB005; mem[3] = 16'h00F0;
        mem[4] = 16'h0000; mem[5] = 16'h0003;
        wlog.delete();
        v_count_i = 11'd0;
        c160 = 0;
        pulse_eof(t);
        for (int v = 1; v <= 200; v++) begin
            v_count_i = 11'(v);
            h_count_i = 11'($urandom_range(0, 2047));
            if (v == 160) c160 = cyc;
            tick(1);
        end
        tick(5);
        check("t2_writes", wlog.size(), 1);
        check_write("t2", 0, c160 + 4, 5, 'h00F0);

        // SKIP on v >= 160
        fill_nop();
        mem[0] = 16'h20A0; mem[1] = 16'h0002; mem[2] = 16'h4010; mem[3] = 16'h0000;
        mem[4] = 16'hB001; mem[5] = 16'h000F; mem[6] = 16'h0000; mem[7] = 16'h0003;
        mem[16] = 16'hB002; mem[17] = 16'h0F00; mem[18] = 16'h0000; mem[19] = 16'h0003;
        wlog.delete();
        v_count_i = 11'd100;
        pulse_eof(t);
        tick(30);
        check("t3a_writes", wlog.size(), 1);
        check_write("t3a", 0, t + 10, 2, 'h0F00);
        wlog.delete();
        v_count_i = 11'd200;
        pulse_eof(t);
        tick(30);
        check("t3b_writes", wlog.size(), 1);
        check_write("t3b", 0, t + 7, 1, 'h000F);

        // JMP to 2046, w1 at 2047, PC wraps to 0
        fill_nop();
        mem[0] = 16'h47FE; mem[1] = 16'h0000; mem[2046] = 16'hB003; mem[2047] = 16'h1234;
        wlog.delete();
        pulse_eof(t);
        tick(12);
        check_write("t4", 0, t + 7, 3, 'h1234);
        check("t4_w1_addr", rd_addr_at[t + 5], 2047);
        check("t4_wrap_rd_en", int'(rd_en_at[t + 7]), 1);
        check("t4_wrap_addr", rd_addr_at[t + 7], 0);
        cop_en_i = 1'b0;
        tick(2);
        check("t4_dis_rd_en", int'(cop_rd_en_o), 0);
        cop_en_i = 1'b1;

        // eof abandons a pending WAIT
        fill_nop();
        mem[0] = 16'h0190; mem[1] = 16'h0002; mem[2] = 16'hB007; mem[3] = 16'h0ABC;
        wlog.delete();
        v_count_i = 11'd300;
        pulse_eof(t);
        tick(10);
        pulse_eof(t2);
        tick(1);
        check("t5_restart_rd_en", int'(rd_en_at[t2 + 1]), 1);
        check("t5_restart_addr", rd_addr_at[t2 + 1], 0);
        tick(10);
        check("t5_no_write", wlog.size(), 0);
        cop_en_i = 1'b0;
        tick(2);
        cop_en_i = 1'b1;

        // cop_en drop during FETCH1 of MOVEP
        fill_nop();
        mem[0] = 16'hB008; mem[1] = 16'h0123; mem[2] = 16'h0000; mem[3] = 16'h0003;
        wlog.delete();
        pulse_eof(t);
        tick(1);
        cop_en_i = 1'b0;
        tick(6);
        check("t6_no_write", wlog.size(), 0);
        check("t6_rd_en_off", int'(rd_en_at[t + 3]), 0);
        cop_en_i = 1'b1;
        tick(1);

        // reset during EXEC of MOVEP
        pulse_eof(t);
        tick(2);
        reset_i = 1'b1;
        tick(2);
        reset_i = 1'b0;
        check("t7_no_write", wlog.size(), 0);
        check("t7_rd_en", int'(rd_en_at[t + 4]), 0);
        check("t7_rd_addr", rd_addr_at[t + 4], 0);
        check("t7_pal_addr", int'(pal_wr_addr_o), 0);
        check("t7_pal_data", int'(pal_wr_data_o), 0);
        tick(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
